// File: rtl/seq_mult4.sv
// -----------------------------------------------------------------------------
// seq_mult4 -- sequential shift-and-add unsigned multiplier.
//
// Captures A_in/B_in on a start request and retires one partial product per
// clock. After WIDTH iterations the sum is written to the registered product
// output, and done strobes for one cycle.
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst      in   1        synchronous active-high reset
//   start    in   1        request a multiplication
//   A_in     in   WIDTH    multiplicand (from enableblock A_out)
//   B_in     in   WIDTH    multiplier   (from enableblock B_out)
//   busy     out  1        high in CALC or DONE
//   done     out  1        one-cycle strobe, product valid
//   product  out  2*WIDTH  registered result, held until next completion
// -----------------------------------------------------------------------------
module seq_mult4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A_in,
  input  logic [WIDTH-1:0]   B_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_acc;
  logic [PW-1:0]      r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [PW-1:0]      r_product;

  logic               w_load;
  logic               w_last;
  logic [PW-1:0]      w_sum;

  // DONE also serves as the acceptance slot for a new start, so a start held
  // high restarts immediately and operations run at one per WIDTH+1 cycles.
  assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last = (r_state == S_CALC) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sum  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: w_state_nxt = w_load ? S_CALC : S_IDLE;
      S_CALC: w_state_nxt = w_last ? S_DONE : S_CALC;
      S_DONE: w_state_nxt = w_load ? S_CALC : S_IDLE;
      default: w_state_nxt = S_IDLE;  // unused code 2'b11 recovers to IDLE
    endcase
  end

  // State register and datapath.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_mcand  <= {{WIDTH{1'b0}}, A_in};
        r_mplier <= B_in;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_CALC) begin
        r_acc    <= w_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        // The final iteration's sum goes straight to the output register.
        if (w_last) begin
          r_product <= w_sum;
        end
      end
    end
  end

  assign busy    = (r_state == S_CALC) || (r_state == S_DONE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult4.sv
// -----------------------------------------------------------------------------
// tb_seq_mult4 -- directed self-checking bench for seq_mult4 (WIDTH = 4).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_seq_mult4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A_in;
  logic [3:0] B_in;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks;
  int errors;
  logic [7:0] last_prod;

  seq_mult4 #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A_in    (A_in),
    .B_in    (B_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation from a single-cycle start pulse; checks timing,
  // product stability during the computation, and the final result.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp);
    A_in  = a;
    B_in  = b;
    start = 1'b1;
    tick();                                  // edge k
    start = 1'b0;
    check({tag, " busy@k"}, 8'(busy), 8'd1);
    check({tag, " done@k"}, 8'(done), 8'd0);
    for (int i = 1; i <= 3; i++) begin       // edges k+1..k+3
      tick();
      check({tag, " early done"}, 8'(done), 8'd0);
      check({tag, " product held"}, product, last_prod);
    end
    tick();                                  // edge k+4
    check({tag, " done@k+4"}, 8'(done), 8'd1);
    check({tag, " product"}, product, exp);
    check({tag, " busy@k+4"}, 8'(busy), 8'd1);
    tick();                                  // edge k+5
    check({tag, " done@k+5"}, 8'(done), 8'd0);
    check({tag, " busy@k+5"}, 8'(busy), 8'd0);
    check({tag, " product kept"}, product, exp);
    last_prod = exp;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    A_in      = '0;
    B_in      = '0;
    last_prod = 8'h00;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 8'(busy), 8'd0);
    check("reset done", 8'(done), 8'd0);
    check("reset product", product, 8'h00);

    // Basic operation: 5 * 9 = 45.
    run_op("op 5x9", 4'b0101, 4'b1001, 8'h2D);

    // Zero operand runs full length, then the maximum product.
    run_op("op 0x15", 4'b0000, 4'b1111, 8'h00);
    run_op("op 15x15", 4'b1111, 4'b1111, 8'hE1);

    // Operand changes and a second start during CALC are ignored.
    A_in  = 4'b0110;
    B_in  = 4'b1101;
    start = 1'b1;
    tick();                                  // edge k
    start = 1'b0;
    tick();                                  // edge k+1
    A_in  = 4'b1000;
    B_in  = 4'b1000;
    start = 1'b1;
    tick();                                  // edge k+2, start ignored
    start = 1'b0;
    tick();                                  // edge k+3
    check("ignore done@k+3", 8'(done), 8'd0);
    check("ignore product held", product, 8'hE1);
    tick();                                  // edge k+4
    check("ignore done@k+4", 8'(done), 8'd1);
    check("ignore product", product, 8'h4E);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ignore no 2nd done", 8'(done), 8'd0);
      check("ignore idle busy", 8'(busy), 8'd0);
    end
    last_prod = 8'h4E;

    // start held high: done every 5 cycles, product stable between pulses.
    A_in  = 4'b0100;
    B_in  = 4'b1011;
    start = 1'b1;
    tick();                                  // first accepting edge
    for (int op = 0; op < 3; op++) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check("b2b no done", 8'(done), 8'd0);
        check("b2b product stable", product, last_prod);
      end
      tick();
      check("b2b done", 8'(done), 8'd1);
      check("b2b product", product, 8'h2C);
      last_prod = 8'h2C;
      if (op == 2) start = 1'b0;
      tick();
      check("b2b done low", 8'(done), 8'd0);
      check("b2b busy", 8'(busy), (op == 2) ? 8'd0 : 8'd1);
    end

    // Reset during the second CALC cycle aborts the operation.
    A_in  = 4'b0101;
    B_in  = 4'b1100;
    start = 1'b1;
    tick();                                  // edge k: CALC
    start = 1'b0;
    tick();                                  // edge k+1: second CALC cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 8'(busy), 8'd0);
    check("abort done", 8'(done), 8'd0);
    check("abort product", product, 8'h00);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort no done", 8'(done), 8'd0);
    end
    last_prod = 8'h00;
    run_op("op 5x12", 4'b0101, 4'b1100, 8'h3C);

    // Reset has priority over start.
    A_in  = 4'b0011;
    B_in  = 4'b0011;
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("rst>start busy", 8'(busy), 8'd0);
    check("rst>start product", product, 8'h00);
    tick();
    check("rst>start still idle", 8'(busy), 8'd0);
    check("rst>start no done", 8'(done), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
